// File: rtl/draw_line.sv
//------------------------------------------------------------------------------
// draw_line
//
// Bresenham line rasteriser. A shape sequencer supplies one line's endpoints
// together with a start pulse. The block then presents one pixel coordinate on
// x/y for every cycle in which oe is high, and pulses done for one cycle after
// the last pixel has been presented.
//
// Ports
//   clk      in   system clock
//   rst      in   synchronous, active-high reset
//   start    in   begin a line; only honoured while idle
//   oe       in   output enable; low stalls pixel stepping
//   x0, y0   in   start point (CORDW bits, unsigned), latched on accepted start
//   x1, y1   in   end point   (CORDW bits, unsigned), latched on accepted start
//   x, y     out  current pixel coordinate
//   drawing  out  x/y hold a valid pixel this cycle (framebuffer write strobe)
//   busy     out  a line is being set up or drawn
//   done     out  one-cycle pulse after the final pixel
//------------------------------------------------------------------------------
module draw_line #(
  parameter int CORDW = 11
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             oe,
  input  logic [CORDW-1:0] x0,
  input  logic [CORDW-1:0] y0,
  input  logic [CORDW-1:0] x1,
  input  logic [CORDW-1:0] y1,
  output logic [CORDW-1:0] x,
  output logic [CORDW-1:0] y,
  output logic             drawing,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_INIT = 2'd1,
    S_DRAW = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic [CORDW-1:0] ONE = {{(CORDW-1){1'b0}}, 1'b1};

  state_t r_state;
  state_t w_next;

  // Endpoints captured at the accepted start; later input changes are ignored.
  logic [CORDW-1:0] r_x0;
  logic [CORDW-1:0] r_y0;
  logic [CORDW-1:0] r_x1;
  logic [CORDW-1:0] r_y1;

  // Bresenham terms: dx >= 0, dy <= 0, err accumulates both.
  logic signed [CORDW:0]   r_dx;
  logic signed [CORDW:0]   r_dy;
  logic signed [CORDW+1:0] r_err;
  logic                    r_sx_neg;
  logic                    r_sy_neg;

  logic [CORDW-1:0] r_x;
  logic [CORDW-1:0] r_y;
  logic             r_busy;
  logic             r_done;

  // Set-up arithmetic, evaluated from the latched endpoints during INIT.
  logic [CORDW-1:0]        w_dx_abs;
  logic [CORDW-1:0]        w_dy_abs;
  logic signed [CORDW:0]   w_dx_init;
  logic signed [CORDW:0]   w_dy_init;
  logic signed [CORDW+1:0] w_err_init;

  // Per-pixel step decision.
  logic signed [CORDW+2:0] w_e2;
  logic signed [CORDW+2:0] w_dx_ext;
  logic signed [CORDW+2:0] w_dy_ext;
  logic                    w_step_x;
  logic                    w_step_y;
  logic signed [CORDW+1:0] w_add_x;
  logic signed [CORDW+1:0] w_add_y;
  logic signed [CORDW+1:0] w_err_next;
  logic [CORDW-1:0]        w_x_next;
  logic [CORDW-1:0]        w_y_next;
  logic                    w_last;
  logic                    w_drawing;

  // Absolute deltas and the initial error term of the line.
  always_comb begin
    w_dx_abs   = {CORDW{1'b0}};
    w_dy_abs   = {CORDW{1'b0}};
    w_dx_init  = {(CORDW+1){1'b0}};
    w_dy_init  = {(CORDW+1){1'b0}};
    w_err_init = {(CORDW+2){1'b0}};
    if (r_x0 < r_x1) begin
      w_dx_abs = r_x1 - r_x0;
    end else begin
      w_dx_abs = r_x0 - r_x1;
    end
    if (r_y0 < r_y1) begin
      w_dy_abs = r_y1 - r_y0;
    end else begin
      w_dy_abs = r_y0 - r_y1;
    end
    w_dx_init  = {1'b0, w_dx_abs};
    w_dy_init  = -{1'b0, w_dy_abs};
    w_err_init = {w_dx_init[CORDW], w_dx_init} + {w_dy_init[CORDW], w_dy_init};
  end

  // Step decision for the current pixel and the resulting next coordinates.
  always_comb begin
    w_e2       = {r_err[CORDW+1], r_err, 1'b0};
    w_dx_ext   = {{2{r_dx[CORDW]}}, r_dx};
    w_dy_ext   = {{2{r_dy[CORDW]}}, r_dy};
    w_step_x   = (w_e2 >= w_dy_ext);
    w_step_y   = (w_e2 <= w_dx_ext);
    w_add_x    = {(CORDW+2){1'b0}};
    w_add_y    = {(CORDW+2){1'b0}};
    w_x_next   = r_x;
    w_y_next   = r_y;
    if (w_step_x) begin
      w_add_x = {r_dy[CORDW], r_dy};
      if (r_sx_neg) begin
        w_x_next = r_x - ONE;
      end else begin
        w_x_next = r_x + ONE;
      end
    end else begin
      w_add_x  = {(CORDW+2){1'b0}};
      w_x_next = r_x;
    end
    if (w_step_y) begin
      w_add_y = {r_dx[CORDW], r_dx};
      if (r_sy_neg) begin
        w_y_next = r_y - ONE;
      end else begin
        w_y_next = r_y + ONE;
      end
    end else begin
      w_add_y  = {(CORDW+2){1'b0}};
      w_y_next = r_y;
    end
    // Both axis terms land in the same cycle when stepping diagonally.
    w_err_next = r_err + w_add_x + w_add_y;
  end

  // Last-pixel detect and the write strobe (combinational on oe so a stall
  // drops the strobe in the same cycle).
  always_comb begin
    w_last    = (r_x == r_x1) && (r_y == r_y1);
    w_drawing = (r_state == S_DRAW) && oe;
  end

  // Next-state logic.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_next = S_INIT;
        end else begin
          w_next = S_IDLE;
        end
      end
      S_INIT: w_next = S_DRAW;
      S_DRAW: begin
        if (oe && w_last) begin
          w_next = S_DONE;
        end else begin
          w_next = S_DRAW;
        end
      end
      S_DONE: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // State register plus busy/done flags derived from the state being entered.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_busy  <= (w_next == S_INIT) || (w_next == S_DRAW);
      r_done  <= (w_next == S_DONE);
    end
  end

  // Endpoint capture, line set-up and pixel stepping.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_x0     <= {CORDW{1'b0}};
      r_y0     <= {CORDW{1'b0}};
      r_x1     <= {CORDW{1'b0}};
      r_y1     <= {CORDW{1'b0}};
      r_dx     <= {(CORDW+1){1'b0}};
      r_dy     <= {(CORDW+1){1'b0}};
      r_err    <= {(CORDW+2){1'b0}};
      r_sx_neg <= 1'b0;
      r_sy_neg <= 1'b0;
      r_x      <= {CORDW{1'b0}};
      r_y      <= {CORDW{1'b0}};
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_x0 <= x0;
            r_y0 <= y0;
            r_x1 <= x1;
            r_y1 <= y1;
          end
        end
        S_INIT: begin
          r_dx     <= w_dx_init;
          r_dy     <= w_dy_init;
          r_err    <= w_err_init;
          // Equal coordinates select the negative direction; that axis never
          // steps anyway because its delta is zero.
          r_sx_neg <= !(r_x0 < r_x1);
          r_sy_neg <= !(r_y0 < r_y1);
          r_x      <= r_x0;
          r_y      <= r_y0;
        end
        S_DRAW: begin
          if (oe && !w_last) begin
            r_err <= w_err_next;
            r_x   <= w_x_next;
            r_y   <= w_y_next;
          end
        end
        S_DONE: begin
          r_err <= r_err;
        end
        default: begin
          r_err <= r_err;
        end
      endcase
    end
  end

  assign x       = r_x;
  assign y       = r_y;
  assign drawing = w_drawing;
  assign busy    = r_busy;
  assign done    = r_done;

endmodule

// File: tb/tb_draw_line.sv
module tb_draw_line;

  localparam int CORDW = 11;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic             oe;
  logic [CORDW-1:0] x0;
  logic [CORDW-1:0] y0;
  logic [CORDW-1:0] x1;
  logic [CORDW-1:0] y1;
  logic [CORDW-1:0] x;
  logic [CORDW-1:0] y;
  logic             drawing;
  logic             busy;
  logic             done;

  draw_line #(.CORDW(CORDW)) dut (
    .clk(clk), .rst(rst), .start(start), .oe(oe),
    .x0(x0), .y0(y0), .x1(x1), .y1(y1),
    .x(x), .y(y), .drawing(drawing), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int px;
    int py;
  } pix_t;

  pix_t m_gen[$];
  pix_t m_q[$];
  int   m_phase     = 0;  // 0 idle, 1 setup, 2 drawing, 3 done pulse
  int   m_drawn     = 0;
  int   m_expcount  = 0;
  int   m_lines     = 0;
  bit   m_after_rst = 1'b0;
  int   checks      = 0;
  int   errors      = 0;

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  function automatic int clampc(input int v);
    if (v < 0) return 0;
    if (v > 2047) return 2047;
    return v;
  endfunction

  // Reference pixel list of a line from the integer Bresenham rules.
  function automatic void build_line(input int ax, input int ay, input int bx, input int by);
    int dx, dy, sx, sy, err, e2, cx, cy;
    m_gen.delete();
    dx  = iabs(bx - ax);
    dy  = -iabs(by - ay);
    sx  = (ax < bx) ? 1 : -1;
    sy  = (ay < by) ? 1 : -1;
    err = dx + dy;
    cx  = ax;
    cy  = ay;
    for (int n = 0; n < 5000; n++) begin
      m_gen.push_back('{cx, cy});
      if (cx == bx && cy == by) break;
      e2 = 2 * err;
      if (e2 >= dy) begin err += dy; cx += sx; end
      if (e2 <= dx) begin err += dx; cy += sy; end
    end
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model advance on each active edge, from the inputs the DUT samples there.
  always @(posedge clk) begin
    if (rst) begin
      m_phase     = 0;
      m_q.delete();
      m_after_rst = 1'b1;
    end else begin
      case (m_phase)
        0: if (start) begin
          build_line(int'(x0), int'(y0), int'(x1), int'(y1));
          m_q         = m_gen;
          m_drawn     = 0;
          m_expcount  = ((iabs(int'(x1) - int'(x0)) > iabs(int'(y1) - int'(y0))) ?
                         iabs(int'(x1) - int'(x0)) : iabs(int'(y1) - int'(y0))) + 1;
          m_phase     = 1;
          m_after_rst = 1'b0;
        end
        1: m_phase = 2;
        2: if (oe) begin
          void'(m_q.pop_front());
          m_drawn++;
          if (m_q.size() == 0) m_phase = 3;
        end
        3: begin
          m_phase = 0;
          m_lines++;
        end
        default: m_phase = 0;
      endcase
    end
  end

  // Compare DUT outputs with the model mid-cycle.
  always @(negedge clk) begin
    check("busy", int'(busy), int'(m_phase == 1 || m_phase == 2));
    check("done", int'(done), int'(m_phase == 3));
    check("drawing", int'(drawing), int'(m_phase == 2 && oe));
    if (m_phase == 2 && m_q.size() > 0) begin
      check("pixel_x", int'(x), m_q[0].px);
      check("pixel_y", int'(y), m_q[0].py);
    end
    if (m_phase == 3) check("pixel_count", m_drawn, m_expcount);
    if (m_phase == 0 && m_after_rst) begin
      check("reset_x", int'(x), 0);
      check("reset_y", int'(y), 0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_line(input int base, input int oe_mode);
    int n;
    n = 0;
    while (m_lines == base && n < 20000) begin
      oe = (oe_mode == 0) ? 1'b1 : 1'($urandom_range(0, 3) != 0);
      tick();
      n++;
    end
    if (m_lines == base) check("line_timeout", m_lines - base, 1);
    oe = 1'b1;
  endtask

  task automatic issue(input int ax, input int ay, input int bx, input int by);
    x0 = 11'(ax); y0 = 11'(ay); x1 = 11'(bx); y1 = 11'(by);
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic run_line(input int ax, input int ay, input int bx, input int by, input int oe_mode);
    int base;
    base = m_lines;
    issue(ax, ay, bx, by);
    wait_line(base, oe_mode);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int sx_lit[6];
    int sy_lit[6];
    int base, n, ax, ay;
    sx_lit = '{0, 0, 1, 1, 2, 2};
    sy_lit = '{0, 1, 2, 3, 4, 5};

    // Hand-computed expectations that pin the reference model.
    build_line(0, 0, 2, 5);
    check("model_steep_len", m_gen.size(), 6);
    for (int i = 0; i < 6 && i < m_gen.size(); i++) begin
      check("model_steep_x", m_gen[i].px, sx_lit[i]);
      check("model_steep_y", m_gen[i].py, sy_lit[i]);
    end
    build_line(200, 200, 400, 200);
    check("model_horiz_len", m_gen.size(), 201);
    check("model_horiz_first_x", m_gen[0].px, 200);
    check("model_horiz_last_x", m_gen[m_gen.size()-1].px, 400);
    check("model_horiz_last_y", m_gen[m_gen.size()-1].py, 200);
    build_line(200, 200, 100, 100);
    check("model_diag_len", m_gen.size(), 101);
    check("model_diag_second_x", m_gen[1].px, 199);
    check("model_diag_last_y", m_gen[m_gen.size()-1].py, 100);
    build_line(5, 5, 5, 5);
    check("model_degen_len", m_gen.size(), 1);

    rst = 1'b1; start = 1'b0; oe = 1'b1;
    x0 = '0; y0 = '0; x1 = '0; y1 = '0;
    tick(); tick(); tick();
    rst = 1'b0;
    tick();

    // Directed lines.
    run_line(200, 200, 400, 200, 0);
    run_line(200, 200, 100, 100, 0);
    run_line(0, 0, 2, 5, 0);
    run_line(5, 5, 5, 5, 0);

    // Stall at pixel (390,390).
    base = m_lines;
    issue(400, 400, 300, 300);
    n = 0;
    while (!(drawing && x == 11'd390 && y == 11'd390) && n < 500) begin tick(); n++; end
    check("stall_reached", int'(x), 390);
    oe = 1'b0;
    tick(); tick(); tick();
    oe = 1'b1;
    wait_line(base, 0);

    // Start pulse with new endpoints while drawing: ignored.
    base = m_lines;
    issue(50, 60, 120, 90);
    for (int i = 0; i < 10; i++) tick();
    issue(700, 3, 9, 800);
    wait_line(base, 0);

    // Start held high through done: next line begins in the following IDLE.
    base = m_lines;
    x0 = 11'd10; y0 = 11'd10; x1 = 11'd13; y1 = 11'd20;
    start = 1'b1;
    tick();
    wait_line(base, 0);
    x0 = 11'd20; y0 = 11'd3; x1 = 11'd7; y1 = 11'd9;
    base = m_lines;
    tick();
    start = 1'b0;
    wait_line(base, 0);

    // Reset while presenting the 50th pixel.
    issue(0, 0, 300, 77);
    n = 0;
    while (!(m_phase == 2 && m_drawn == 49) && n < 500) begin tick(); n++; end
    check("reset_point_reached", m_drawn, 49);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    run_line(30, 40, 10, 45, 0);

    // Extremes of the coordinate range.
    run_line(0, 2047, 2047, 0, 0);
    run_line(2047, 0, 0, 5, 1);

    // Randomised short lines with random output enable.
    for (int k = 0; k < 16; k++) begin
      ax = $urandom_range(0, 2047);
      ay = $urandom_range(0, 2047);
      run_line(ax, ay, clampc(ax + $urandom_range(0, 80) - 40),
               clampc(ay + $urandom_range(0, 80) - 40), 1);
    end

    tick(); tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
